// File: rtl/clock_divider_ctrl.sv
// Sequencing controller for a dynamic clock divider: accepts divide-ratio changes
// and walks each through gate -> drain -> load -> settle -> ungate.
module clock_divider_ctrl #(
  parameter int DIVIDER_WIDTH  = 8,
  parameter int DRAIN_CYCLES   = 4,
  parameter int SETTLE_PERIODS = 2,
  parameter int RESET_DIVIDER  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [DIVIDER_WIDTH-1:0] req_divider_i,
  output logic [DIVIDER_WIDTH-1:0] divider_o,
  output logic                     div_rst_o,
  output logic                     clk_en_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     clamped_o,
  output logic [2:0]               state_o
);

  localparam int W  = DIVIDER_WIDTH;
  localparam int SW = DIVIDER_WIDTH + 4;

  // Out-of-range parameters are pulled into their legal ranges.
  localparam int DRAIN_EFF  = (DRAIN_CYCLES < 1) ? 1 :
                              ((DRAIN_CYCLES > 255) ? 255 : DRAIN_CYCLES);
  localparam int SETTLE_EFF = (SETTLE_PERIODS < 1) ? 1 :
                              ((SETTLE_PERIODS > 15) ? 15 : SETTLE_PERIODS);
  localparam logic [W-1:0] RESET_DIV = (RESET_DIVIDER == 0) ? W'(1) : W'(RESET_DIVIDER);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATE   = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Handshake: a request transfers on a clk_i edge where req_valid_i and
  // req_ready_o are both high; req_ready_o depends on state only, and
  // req_divider_i is sampled solely on that edge.
  state_t         state;
  state_t         next_state;
  logic [W-1:0]   pending;
  logic [7:0]     drain_cnt;
  logic [SW-1:0]  settle_cnt;
  logic [SW-1:0]  settle_target;
  logic [W-1:0]   req_eff;
  logic           accept;

  assign req_ready_o   = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign state_o       = state;
  assign accept        = req_valid_i && req_ready_o;
  assign req_eff       = (req_divider_i == '0) ? W'(1) : req_divider_i;
  // Wide enough that 15 * (2^W - 1) never wraps.
  assign settle_target = SW'(SETTLE_EFF) * SW'(pending);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (req_eff == divider_o) ? DONE : GATE;
        end
      end
      GATE: begin
        if (drain_cnt == 8'(DRAIN_EFF - 1)) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == settle_target - SW'(1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from next_state so they line up with the state
  // they describe, keeping div_rst_o and clk_en_o mutually exclusive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pending    <= RESET_DIV;
      drain_cnt  <= '0;
      settle_cnt <= '0;
      divider_o  <= RESET_DIV;
      div_rst_o  <= 1'b0;
      clk_en_o   <= 1'b1;
      done_o     <= 1'b0;
      clamped_o  <= 1'b0;
    end else begin
      state      <= next_state;
      if (accept) begin
        pending <= req_eff;
      end
      drain_cnt  <= (state == GATE) ? drain_cnt + 8'd1 : 8'd0;
      settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
      if (next_state == LOAD && state != LOAD) begin
        divider_o <= pending;
      end
      div_rst_o  <= (next_state == LOAD);
      clk_en_o   <= (next_state == IDLE) || (next_state == DONE);
      done_o     <= (next_state == DONE);
      clamped_o  <= accept && (req_divider_i == '0);
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: directed and random divider changes checked
// against a timeline computed arithmetically from the sequencing rules.
module tb_clock_divider_ctrl;

  localparam int W      = 8;
  localparam int DRAIN  = 4;
  localparam int SETTLE = 2;
  localparam int RDIV   = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_divider = '0;
  logic         req_ready, div_rst, clk_en, busy, done, clamped;
  logic [W-1:0] divider;
  logic [2:0]   state;

  logic         req_valid2 = 1'b0;
  logic [W-1:0] req_divider2 = '0;
  logic         req_ready2, div_rst2, clk_en2, busy2, done2, clamped2;
  logic [W-1:0] divider2;
  logic [2:0]   state2;

  int n_cmp = 0;
  int n_err = 0;
  int cur_div;

  always #5 clk = ~clk;

  clock_divider_ctrl #(
    .DIVIDER_WIDTH(W), .DRAIN_CYCLES(DRAIN), .SETTLE_PERIODS(SETTLE), .RESET_DIVIDER(RDIV)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_divider_i(req_divider), .divider_o(divider), .div_rst_o(div_rst),
    .clk_en_o(clk_en), .busy_o(busy), .done_o(done), .clamped_o(clamped), .state_o(state)
  );

  clock_divider_ctrl #(
    .DIVIDER_WIDTH(W), .DRAIN_CYCLES(DRAIN), .SETTLE_PERIODS(15), .RESET_DIVIDER(RDIV)
  ) dut_max (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
    .req_divider_i(req_divider2), .divider_o(divider2), .div_rst_o(div_rst2),
    .clk_en_o(clk_en2), .busy_o(busy2), .done_o(done2), .clamped_o(clamped2), .state_o(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int exp_div);
    check({tag, ".divider"}, 32'(divider), 32'(exp_div));
    check({tag, ".clk_en"}, 32'(clk_en), 1);
    check({tag, ".div_rst"}, 32'(div_rst), 0);
    check({tag, ".ready"}, 32'(req_ready), 1);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
  endtask

  // Called at a negedge while the DUT is idle. Runs one request through its
  // whole timeline (or until abort_at, where reset is applied) and returns at
  // the negedge of the next idle cycle. If hold is set, req_valid stays high
  // with hold_val for the whole sequence.
  task automatic run_request(input int v, input bit hold, input int hold_val, input int abort_at);
    int d, n;
    bit same;
    d    = (v == 0) ? 1 : v;
    same = (d == cur_div);
    n    = same ? 1 : DRAIN + 2 + SETTLE * d;
    req_valid   = 1'b1;
    req_divider = W'(v);
    check("accept.ready", 32'(req_ready), 1);
    @(negedge clk);
    if (hold) req_divider = W'(hold_val);
    else req_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      check($sformatf("c%0d.clk_en", k), 32'(clk_en), 32'(!(!same && k <= n - 1)));
      check($sformatf("c%0d.div_rst", k), 32'(div_rst), 32'(!same && k == DRAIN + 1));
      check($sformatf("c%0d.divider", k), 32'(divider),
            32'((!same && k >= DRAIN + 1) ? d : cur_div));
      check($sformatf("c%0d.done", k), 32'(done), 32'(k == n));
      check($sformatf("c%0d.clamped", k), 32'(clamped), 32'(k == 1 && v == 0));
      check($sformatf("c%0d.busy", k), 32'(busy), 1);
      check($sformatf("c%0d.ready", k), 32'(req_ready), 0);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        cur_div = RDIV;
        check_idle("abort", RDIV);
        check("abort.clamped", 32'(clamped), 0);
        return;
      end
      @(negedge clk);
    end
    cur_div = d;
    check("post.ready", 32'(req_ready), 1);
    check("post.busy", 32'(busy), 0);
    check("post.done", 32'(done), 0);
    check("post.divider", 32'(divider), 32'(cur_div));
  endtask

  initial begin
    int v, hv, cyc;
    bit hold;
    cur_div = RDIV;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset", RDIV);
    check("reset.clamped", 32'(clamped), 0);
    @(negedge clk);
    check_idle("idle", RDIV);

    // Full change to 5, same-value 5, clamp of 0
    run_request(5, 1'b0, 0, 0);
    run_request(5, 1'b0, 0, 0);
    run_request(0, 1'b0, 0, 0);

    // Request 9 held valid while busy changing to 3; accepted only afterwards
    run_request(3, 1'b1, 9, 0);
    run_request(9, 1'b0, 0, 0);

    // Reset in the middle of SETTLE
    run_request(6, 1'b0, 0, DRAIN + 3);
    repeat (2) @(negedge clk);
    check_idle("after_abort", RDIV);

    // Reset takes priority over a simultaneous request
    rst = 1'b1;
    req_valid = 1'b1;
    req_divider = 8'd7;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    check_idle("rst_prio", RDIV);
    @(negedge clk);
    check_idle("rst_prio2", RDIV);

    // Random changes, some same-value, some zero, some held while busy
    hold = 1'b0;
    hv = 0;
    for (int i = 0; i < 12; i++) begin
      if (hold) v = hv;
      else if ($urandom_range(0, 3) == 0) v = cur_div;
      else v = $urandom_range(0, 9);
      hold = ($urandom_range(0, 2) == 0);
      hv = $urandom_range(1, 9);
      run_request(v, hold, hv, 0);
    end
    if (hold) begin
      run_request(hv, 1'b0, 0, 0);
    end

    // Largest ratio with the largest settle multiplier
    check("max.ready", 32'(req_ready2), 1);
    req_valid2 = 1'b1;
    req_divider2 = 8'd255;
    @(negedge clk);
    req_valid2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("max.done_cycle", 32'(cyc), 32'(DRAIN + 2 + 15 * 255));
    check("max.divider", 32'(divider2), 255);
    check("max.clk_en", 32'(clk_en2), 1);
    @(negedge clk);
    check("max.ready_back", 32'(req_ready2), 1);
    check("max.done_low", 32'(done2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
